// File: rtl/ifsram_pkg.sv
// Shared encodings for the ifmap SRAM row scheduler and the ifmap read engine.
package ifsram_pkg;

  localparam int MIN_ROWS = 3;

  typedef enum logic [2:0] {
    RS_IDLE         = 3'd0,
    RS_UP_PADDING   = 3'd1,
    RS_THREEROW     = 3'd2,
    RS_TWOROW       = 3'd3,
    RS_ONEROW       = 3'd4,
    RS_DOWN_PADDING = 3'd5
  } row_state_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REQ  = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_READ_REQ  = 3'd3,
    S_READ_WAIT = 3'd4,
    S_DONE      = 3'd5
  } sched_state_e;

endpackage

// File: rtl/ifsram_rot3.sv
// Mod-3 rotation counter giving the THREEROW/TWOROW/ONEROW code for interior rows.
module ifsram_rot3
  import ifsram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [2:0] o_code
);

  logic [1:0] r_phase;

  // Phase steps 0,1,2,0,... once per interior row read; cleared at layer start
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_phase <= 2'd0;
    end else if (i_clear) begin
      r_phase <= 2'd0;
    end else if (i_advance) begin
      r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
    end
  end

  // Map the rotation phase onto the circular-buffer row-state code
  always_comb begin
    o_code = RS_THREEROW;
    case (r_phase)
      2'd1:    o_code = RS_TWOROW;
      2'd2:    o_code = RS_ONEROW;
      default: o_code = RS_THREEROW;
    endcase
  end

endmodule

// File: rtl/ifsram_row_sched.sv
// Row scheduler: loads input rows into the 3-row ifmap SRAM and sequences reads per output row.
module ifsram_row_sched
  import ifsram_pkg::*;
#(
  parameter int RW = 6
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] cfg_rows,
  input  logic          layer_start,
  output logic          sched_busy,
  output logic          layer_done,
  output logic          cfg_err,
  output logic          if_load_start,
  output logic [RW-1:0] if_load_row,
  input  logic          if_load_done,
  output logic          if_read_start,
  input  logic          if_read_done,
  output logic [2:0]    current_state,
  output logic [RW-1:0] out_row
);

  sched_state_e  r_state;
  sched_state_e  w_nextState;

  logic [RW-1:0] r_rowsQ;
  logic [RW-1:0] r_outRow;
  logic [RW-1:0] r_loadRow;
  logic [1:0]    r_need;
  logic [2:0]    r_curState;
  logic          r_cfgErr;

  logic [RW-1:0] w_lastRow;
  logic [RW-1:0] w_nextRow;
  logic [RW-1:0] w_readRow;
  logic          w_isLast;
  logic          w_moreLoads;
  logic          w_startOk;
  logic          w_startBad;
  logic          w_loadAck;
  logic          w_readAck;
  logic          w_enterRead;
  logic          w_rotAdv;
  logic [2:0]    w_rotCode;
  logic [2:0]    w_readCode;

  assign w_lastRow   = r_rowsQ - RW'(1);
  assign w_nextRow   = r_outRow + RW'(1);
  assign w_isLast    = (r_outRow == w_lastRow);
  assign w_moreLoads = (w_nextRow <= (r_rowsQ - RW'(2)));

  // A read entered from READ_WAIT belongs to the next output row, otherwise the current one
  assign w_readRow = (r_state == S_READ_WAIT) ? w_nextRow : r_outRow;
  assign w_rotAdv  = w_enterRead && (w_readRow != '0) && (w_readRow != w_lastRow);

  ifsram_rot3 u_rot3 (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_startOk),
    .i_advance (w_rotAdv),
    .o_code    (w_rotCode)
  );

  // Scheduler state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and one-cycle control strobes for the datapath
  always_comb begin
    w_nextState = r_state;
    w_startOk   = 1'b0;
    w_startBad  = 1'b0;
    w_loadAck   = 1'b0;
    w_readAck   = 1'b0;
    w_enterRead = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (layer_start) begin
          if (cfg_rows >= RW'(MIN_ROWS)) begin
            w_startOk   = 1'b1;
            w_nextState = S_LOAD_REQ;
          end else begin
            w_startBad = 1'b1;
          end
        end
      end
      S_LOAD_REQ: w_nextState = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        if (if_load_done) begin
          w_loadAck = 1'b1;
          if (r_need == 2'd1) begin
            w_enterRead = 1'b1;
            w_nextState = S_READ_REQ;
          end else begin
            w_nextState = S_LOAD_REQ;
          end
        end
      end
      S_READ_REQ: w_nextState = S_READ_WAIT;
      S_READ_WAIT: begin
        if (if_read_done) begin
          w_readAck = 1'b1;
          if (w_isLast) begin
            w_nextState = S_DONE;
          end else if (w_moreLoads) begin
            w_nextState = S_LOAD_REQ;
          end else begin
            w_enterRead = 1'b1;
            w_nextState = S_READ_REQ;
          end
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Row-state code for the read about to be issued: padding at the edges, rotation inside
  always_comb begin
    w_readCode = w_rotCode;
    if (w_readRow == '0) begin
      w_readCode = RS_UP_PADDING;
    end else if (w_readRow == w_lastRow) begin
      w_readCode = RS_DOWN_PADDING;
    end
  end

  // Row counters, load budget, error pulse and the held row-state code
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rowsQ    <= '0;
      r_outRow   <= '0;
      r_loadRow  <= '0;
      r_need     <= 2'd0;
      r_curState <= RS_IDLE;
      r_cfgErr   <= 1'b0;
    end else begin
      r_cfgErr <= w_startBad;
      if (w_startOk) begin
        r_rowsQ   <= cfg_rows;
        r_outRow  <= '0;
        r_loadRow <= '0;
        r_need    <= 2'd2;
      end
      if (w_loadAck) begin
        r_loadRow <= r_loadRow + RW'(1);
        r_need    <= r_need - 2'd1;
      end
      if (w_readAck && !w_isLast) begin
        r_outRow <= w_nextRow;
        if (w_moreLoads) begin
          r_need <= 2'd1;
        end
      end
      if (w_enterRead) begin
        r_curState <= w_readCode;
      end else if (w_nextState == S_DONE) begin
        r_curState <= RS_IDLE;
      end
    end
  end

  assign sched_busy    = (r_state != S_IDLE);
  assign layer_done    = (r_state == S_DONE);
  assign cfg_err       = r_cfgErr;
  assign if_load_start = (r_state == S_LOAD_REQ);
  assign if_load_row   = if_load_start ? r_loadRow : '0;
  assign if_read_start = (r_state == S_READ_REQ);
  assign current_state = r_curState;
  assign out_row       = r_outRow;

endmodule

// File: tb/tb_ifsram_row_sched.sv
// Self-checking bench for ifsram_row_sched: event-order model plus literal sequence pins.
module tb_ifsram_row_sched;

  localparam int RW       = 6;
  localparam int RESP_DLY = 3;
  localparam int BUDGET   = 600;

  typedef struct {
    int kind;   // 0 load, 1 read, 2 layer done
    int row;
    int code;
  } ev_t;

  logic          clk;
  logic          reset;
  logic [RW-1:0] cfg_rows;
  logic          layer_start;
  logic          sched_busy;
  logic          layer_done;
  logic          cfg_err;
  logic          if_load_start;
  logic [RW-1:0] if_load_row;
  logic          if_load_done;
  logic          if_read_start;
  logic          if_read_done;
  logic [2:0]    current_state;
  logic [RW-1:0] out_row;

  logic respLoad;
  logic respRead;
  logic injRead;

  int   checks;
  int   failures;
  ev_t  expQ[$];
  int   logLoad[$];
  int   logRow[$];
  int   logCode[$];
  int   doneCnt;
  int   expCur;
  bit   expBusy;
  bit   expCfgErr;
  bit   monEn;
  bit   sawLoad;
  bit   sawRead;
  bit   prevReadDone;
  int   loadCnt;
  int   readCnt;

  int lit3[3] = '{1, 2, 5};
  int lit4[4] = '{1, 2, 3, 5};
  int lit5[5] = '{1, 2, 3, 4, 5};
  int lit6[6] = '{1, 2, 3, 4, 2, 5};

  assign if_load_done = respLoad;
  assign if_read_done = respRead | injRead;

  ifsram_row_sched #(.RW(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_rows      (cfg_rows),
    .layer_start   (layer_start),
    .sched_busy    (sched_busy),
    .layer_done    (layer_done),
    .cfg_err       (cfg_err),
    .if_load_start (if_load_start),
    .if_load_row   (if_load_row),
    .if_load_done  (if_load_done),
    .if_read_start (if_read_start),
    .if_read_done  (if_read_done),
    .current_state (current_state),
    .out_row       (out_row)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Row-state code an output row must carry, straight from the padding/rotation rule
  function automatic int rowCode(input int h, input int r);
    if (r == 0)     return 1;
    if (r == h - 1) return 5;
    return 2 + ((r - 1) % 3);
  endfunction

  function automatic int litCode(input int h, input int i);
    case (h)
      3:       return lit3[i];
      4:       return lit4[i];
      5:       return lit5[i];
      default: return lit6[i];
    endcase
  endfunction

  // Expected request order: load row r+1 must precede the read of row r
  task automatic buildLayer(input int h);
    ev_t ev;
    expQ.delete();
    ev = '{kind: 0, row: 0, code: 0};
    expQ.push_back(ev);
    for (int r = 0; r < h; r++) begin
      if (r + 1 <= h - 1) begin
        ev = '{kind: 0, row: r + 1, code: 0};
        expQ.push_back(ev);
      end
      ev = '{kind: 1, row: r, code: rowCode(h, r)};
      expQ.push_back(ev);
    end
    ev = '{kind: 2, row: 0, code: 0};
    expQ.push_back(ev);
  endtask

  // Per-cycle comparison of DUT outputs against the model
  task automatic compareCycle();
    ev_t ev;
    int  kindAct;
    sawLoad = 1'b0;
    sawRead = 1'b0;
    if (monEn) begin
      checkOutput("one_request", int'(if_load_start) + int'(if_read_start) + int'(layer_done), (if_load_start || if_read_start || layer_done) ? 1 : 0);
      if (if_load_start || if_read_start || layer_done) begin
        kindAct = if_load_start ? 0 : (if_read_start ? 1 : 2);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", kindAct, -1);
        end else begin
          ev = expQ.pop_front();
          checkOutput("event_kind", kindAct, ev.kind);
          if (kindAct == 0) begin
            checkOutput("load_row", int'(if_load_row), ev.row);
            logLoad.push_back(int'(if_load_row));
            sawLoad = 1'b1;
          end else if (kindAct == 1) begin
            checkOutput("read_row", int'(out_row), ev.row);
            expCur = ev.code;
            logRow.push_back(int'(out_row));
            logCode.push_back(int'(current_state));
            sawRead = 1'b1;
          end else begin
            expCur = 0;
            doneCnt++;
            checkOutput("done_latency", int'(prevReadDone), 1);
          end
        end
      end
      checkOutput("current_state", int'(current_state), expCur);
      checkOutput("sched_busy", int'(sched_busy), int'(expBusy));
      checkOutput("cfg_err", int'(cfg_err), int'(expCfgErr));
      if (layer_done) expBusy = 1'b0;
    end
    prevReadDone = if_read_done;
  endtask

  // Engine responder: done pulse RESP_DLY cycles after each request
  task automatic respond();
    respLoad = (loadCnt == 1);
    respRead = (readCnt == 1);
    if (loadCnt > 0) loadCnt--;
    if (readCnt > 0) readCnt--;
    if (if_load_start) loadCnt = RESP_DLY;
    if (if_read_start) readCnt = RESP_DLY;
  endtask

  task automatic tick();
    @(negedge clk);
    compareCycle();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic applyStimulus(input int h);
    cfg_rows    = RW'(h);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    cfg_rows    = RW'(2);
    logLoad.delete();
    logRow.delete();
    logCode.delete();
    doneCnt = 0;
    buildLayer(h);
    expBusy = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},   int'(sched_busy), 0);
    checkOutput({tag, "_ldst"},   int'(if_load_start), 0);
    checkOutput({tag, "_ldrow"},  int'(if_load_row), 0);
    checkOutput({tag, "_rdst"},   int'(if_read_start), 0);
    checkOutput({tag, "_state"},  int'(current_state), 0);
    checkOutput({tag, "_outrow"}, int'(out_row), 0);
    checkOutput({tag, "_done"},   int'(layer_done), 0);
    checkOutput({tag, "_cfgerr"}, int'(cfg_err), 0);
  endtask

  // mode 0 plain, 1 restart attempt plus spurious read-done, 2 reset during row 2 read
  task automatic runLayer(input int mode);
    int n;
    int phase;
    n     = 0;
    phase = 0;
    while ((expQ.size() != 0 || expBusy) && n < BUDGET) begin
      tick();
      n++;
      if (n == 1) checkOutput("start_latency", logLoad.size(), 1);
      if (mode == 1) begin
        if (phase == 1) begin
          layer_start = 1'b0;
          injRead     = 1'b0;
          phase       = 2;
        end else if (phase == 0 && sawLoad && logRow.size() >= 1) begin
          layer_start = 1'b1;
          cfg_rows    = RW'(3);
          injRead     = 1'b1;
          phase       = 1;
        end
      end
      if (mode == 2 && sawRead && logRow[$] == 2) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expQ.delete();
        expBusy = 1'b0;
        expCur  = 0;
        checkAllZero("midreset");
        break;
      end
    end
    checkOutput("layer_complete", expQ.size(), 0);
  endtask

  task automatic checkLogs(input string tag, input int h);
    checkOutput({tag, "_nloads"}, logLoad.size(), h);
    checkOutput({tag, "_nreads"}, logRow.size(), h);
    checkOutput({tag, "_ndone"}, doneCnt, 1);
    for (int i = 0; i < h; i++) begin
      if (i < logLoad.size()) checkOutput($sformatf("%s_load%0d", tag, i), logLoad[i], i);
      if (i < logRow.size()) begin
        checkOutput($sformatf("%s_row%0d", tag, i), logRow[i], i);
        checkOutput($sformatf("%s_code%0d", tag, i), logCode[i], litCode(h, i));
      end
    end
  endtask

  // Directed sequence
  initial begin
    checks = 0; failures = 0; doneCnt = 0; expCur = 0;
    expBusy = 1'b0; expCfgErr = 1'b0; monEn = 1'b0; prevReadDone = 1'b0;
    loadCnt = 0; readCnt = 0; respLoad = 1'b0; respRead = 1'b0; injRead = 1'b0;
    reset = 1'b0; cfg_rows = '0; layer_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    checkAllZero("reset");
    monEn = 1'b1;

    $display("[TB] H=3 minimum layer");
    applyStimulus(3);
    runLayer(0);
    checkLogs("h3", 3);

    $display("[TB] H=6 layer");
    applyStimulus(6);
    runLayer(0);
    checkLogs("h6", 6);

    $display("[TB] cfg_rows=2 rejected");
    logLoad.delete();
    cfg_rows    = RW'(2);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    expCfgErr   = 1'b1;
    tick();
    expCfgErr   = 1'b0;
    tick();
    tick();
    checkOutput("cfgerr_no_load", logLoad.size(), 0);

    $display("[TB] H=5 with mid-layer start and spurious read-done");
    applyStimulus(5);
    runLayer(1);
    checkLogs("h5", 5);

    $display("[TB] H=6 reset during row 2 read");
    applyStimulus(6);
    runLayer(2);
    for (int i = 0; i < 6; i++) tick();
    injRead = 1'b1;
    tick();
    injRead = 1'b0;
    tick();
    checkOutput("post_reset_idle", int'(sched_busy), 0);
    applyStimulus(6);
    runLayer(0);
    checkLogs("h6r", 6);

    $display("[TB] back-to-back H=4 then H=3");
    applyStimulus(4);
    runLayer(0);
    checkLogs("h4", 4);
    checkOutput("between_state", int'(current_state), 0);
    applyStimulus(3);
    runLayer(0);
    checkLogs("h3b", 3);
    tick();
    checkOutput("final_state", int'(current_state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
